// File: rtl/an_decode_seq.sv
// Multi-cycle AN-code (A=47) single-error-correcting decoder: residue, error search
// and restoring division share one serial add/compare/subtract datapath.
//
// state | meaning
// IDLE  | waiting for a codeword, in_ready high
// RES   | bit-serial residue of the received word, MSB first
// SRCH  | match residue against +/-2^i mod A, fix one bit on a consistent match
// DIV   | restoring division of the (corrected) word by A
// DONE  | result presented until accepted
module an_decode_seq #(
  parameter int A    = 47,
  parameter int AN_W = 23,
  parameter int N_W  = 17,
  parameter int R_W  = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [AN_W-1:0] in_code,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N_W-1:0]  out_data,
  output logic            out_corrected,
  output logic            out_uncorrect
);

  localparam int IDX_W = $clog2(AN_W);
  localparam logic [R_W:0]     A_C     = (R_W+1)'(A);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(AN_W-1);

  typedef enum logic [2:0] {S_IDLE, S_RES, S_SRCH, S_DIV, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [AN_W-1:0]  r_code;
  logic [R_W:0]     r_res;
  logic [R_W:0]     r_p;
  logic [IDX_W-1:0] r_idx;
  logic [N_W-1:0]   r_quot;
  logic             r_corr, r_unc;

  logic             w_bit, w_ge, w_match, w_acc, w_idx_zero, w_idx_top;
  logic [R_W:0]     w_sum, w_red, w_p2, w_p2_red, w_neg_p;

  // One shared step: residue accumulation in RES, remainder/quotient bit in DIV.
  assign w_bit      = r_code[r_idx];
  assign w_sum      = {r_res[R_W-1:0], w_bit};
  assign w_ge       = (w_sum >= A_C);
  assign w_red      = w_ge ? (w_sum - A_C) : w_sum;
  assign w_p2       = {r_p[R_W-1:0], 1'b0};
  assign w_p2_red   = (w_p2 >= A_C) ? (w_p2 - A_C) : w_p2;
  assign w_neg_p    = A_C - r_p;
  assign w_match    = ((r_res == r_p) && w_bit) || ((r_res == w_neg_p) && !w_bit);
  assign w_acc      = in_valid && (r_state == S_IDLE);
  assign w_idx_zero = (r_idx == '0);
  assign w_idx_top  = (r_idx == IDX_TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_acc) w_state_nxt = S_RES;
      S_RES:  if (w_idx_zero) w_state_nxt = (w_red == '0) ? S_DIV : S_SRCH;
      S_SRCH: if (w_match || w_idx_top) w_state_nxt = S_DIV;
      S_DIV:  if (w_idx_zero) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready      = (r_state == S_IDLE);
    out_valid     = (r_state == S_DONE);
    out_data      = (r_state == S_DONE) ? r_quot : '0;
    out_corrected = (r_state == S_DONE) && r_corr;
    out_uncorrect = (r_state == S_DONE) && r_unc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code <= '0;
      r_res  <= '0;
      r_p    <= '0;
      r_idx  <= '0;
      r_quot <= '0;
      r_corr <= 1'b0;
      r_unc  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_acc) begin
          r_code <= in_code;
          r_res  <= '0;
          r_idx  <= IDX_TOP;
          r_quot <= '0;
          r_corr <= 1'b0;
          r_unc  <= 1'b0;
        end
        S_RES: begin
          r_res <= w_red;
          if (!w_idx_zero)        r_idx <= r_idx - 1'b1;
          else if (w_red == '0)   r_idx <= IDX_TOP;
          else begin
            r_idx <= '0;
            r_p   <= (R_W+1)'(1);
          end
        end
        S_SRCH: begin
          // Leaving the search: residue register is reused as the division remainder.
          if (w_match) begin
            r_code[r_idx] <= ~w_bit;
            r_corr        <= 1'b1;
            r_res         <= '0;
            r_idx         <= IDX_TOP;
          end else if (w_idx_top) begin
            r_unc <= 1'b1;
            r_res <= '0;
            r_idx <= IDX_TOP;
          end else begin
            r_idx <= r_idx + 1'b1;
            r_p   <= w_p2_red;
          end
        end
        S_DIV: begin
          r_res  <= w_red;
          r_quot <= {r_quot[N_W-2:0], w_ge};
          if (!w_idx_zero) r_idx <= r_idx - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_an_decode_seq.sv
// Self-checking bench for an_decode_seq: directed table, backpressure, mid-run reset,
// back-to-back handshakes and random words against an arithmetic reference model.
module tb_an_decode_seq;

  localparam int A = 47;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_data;
  logic        out_corrected;
  logic        out_uncorrect;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  an_decode_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_corrected(out_corrected), .out_uncorrect(out_uncorrect)
  );

  typedef struct {
    logic [22:0] code;
    logic [16:0] data;
    logic        corr;
    logic        unc;
    int          s;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a single-bit error at k is the first k whose flip yields a multiple of A.
  function automatic vec_t model(input logic [22:0] c);
    vec_t v;
    int unsigned x, y;
    x = c;
    v.code = c;
    v.corr = 1'b0;
    v.unc  = 1'b0;
    v.s    = 0;
    v.data = 17'(x / A);
    if (x % A != 0) begin
      v.unc = 1'b1;
      v.s   = 23;
      for (int k = 0; k < 23; k++) begin
        y = x ^ (32'd1 << k);
        if (y % A == 0) begin
          v.data = 17'(y / A);
          v.corr = 1'b1;
          v.unc  = 1'b0;
          v.s    = k + 1;
          break;
        end
      end
    end
    return v;
  endfunction

  task automatic run_word(input vec_t v, input string tag);
    int cnt;
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1;
    in_code  = v.code;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk({tag, "_in_ready_busy"}, in_ready, 0);
    cnt = 0;
    while (!out_valid && cnt < 200) begin
      @(posedge clk);
      cnt++;
      #1;
    end
    chk({tag, "_latency"}, cnt, 46 + v.s);
    chk({tag, "_data"}, out_data, v.data);
    chk({tag, "_corrected"}, out_corrected, v.corr);
    chk({tag, "_uncorrect"}, out_uncorrect, v.unc);
    @(posedge clk);
    #1;
    chk({tag, "_released"}, {out_valid, in_ready}, 2'b01);
  endtask

  vec_t        tbl[8];
  vec_t        v;
  logic [22:0] bw[3];
  logic [16:0] bd[3];
  int          acc_n, out_n, last_acc, cyc, cnt;
  logic        took_in, took_out;

  initial begin
    tbl[0] = '{23'd57011,   17'd1213,  1'b0, 1'b0, 0};
    tbl[1] = '{23'd56979,   17'd1213,  1'b1, 1'b0, 6};
    tbl[2] = '{23'd57075,   17'd1213,  1'b1, 1'b0, 7};
    tbl[3] = '{23'd57043,   17'd1213,  1'b0, 1'b1, 23};
    tbl[4] = '{23'd0,       17'd0,     1'b0, 1'b0, 0};
    tbl[5] = '{23'd8388607, 17'd47409, 1'b0, 1'b0, 0};
    tbl[6] = '{23'd4251315, 17'd1213,  1'b1, 1'b0, 23};
    tbl[7] = '{23'd57010,   17'd1213,  1'b1, 1'b0, 1};

    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b1;
    #12;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_outputs", {out_valid, out_corrected, out_uncorrect}, 0);
    chk("reset_data", out_data, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_word(tbl[i], $sformatf("tbl%0d", i));

    // Backpressure: result must hold while out_ready is low.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 23'd56979;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 200) begin
      @(posedge clk);
      cnt++;
      #1;
    end
    chk("bp_latency", cnt, 52);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold", {out_valid, in_ready, out_corrected, out_uncorrect}, 4'b1010);
      chk("bp_data", out_data, 1213);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 chk("bp_release", {out_valid, in_ready}, 2'b01);

    // Asynchronous reset during SRCH of a word with its error at bit 5.
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = 23'd56979;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (25) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_outputs", {out_valid, out_corrected, out_uncorrect}, 0);
    chk("rst_data", out_data, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst_in_ready", in_ready, 1);
    repeat (60) @(posedge clk);
    #1 chk("rst_no_output", out_valid, 0);
    run_word(tbl[2], "after_rst");

    // Back-to-back: in_valid held high across three clean words.
    bw[0] = 23'd4700;    bd[0] = 17'd100;
    bw[1] = 23'd235000;  bd[1] = 17'd5000;
    bw[2] = 23'd8388560; bd[2] = 17'd47408;
    acc_n = 0; out_n = 0; last_acc = 0; cyc = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_code  = bw[0];
    while ((acc_n < 3 || out_n < 3) && cyc < 600) begin
      chk("b2b_excl", in_ready & out_valid, 0);
      took_in  = in_ready && in_valid;
      took_out = out_valid && out_ready;
      if (took_out) begin
        if (out_n < 3) chk($sformatf("b2b_data%0d", out_n), out_data, bd[out_n]);
        out_n++;
      end
      if (took_in) begin
        if (acc_n > 0) chk("b2b_spacing", cyc - last_acc, 48);
        last_acc = cyc;
        acc_n++;
      end
      @(posedge clk);
      #1;
      if (took_in) begin
        if (acc_n < 3) in_code = bw[acc_n];
        else           in_valid = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    chk("b2b_accepted", acc_n, 3);
    chk("b2b_outputs", out_n, 3);
    repeat (5) @(posedge clk);
    #1 chk("b2b_no_dup", out_valid, 0);

    // Random words: clean multiples, single flips and arbitrary values.
    for (int i = 0; i < 40; i++) begin
      logic [22:0] c;
      case ($urandom_range(0, 2))
        0:       c = 23'($urandom_range(0, 178481) * A);
        1:       c = 23'($urandom_range(0, 178481) * A) ^ (23'd1 << $urandom_range(0, 22));
        default: c = 23'($urandom);
      endcase
      v = model(c);
      run_word(v, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
